// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

   localparam int          XLEN             = 32;
   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory, the redirect source and decode.
interface instruction_fetch_unit_if;
   import fetch_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   // out_valid/out_ready: a transfer happens on a rising edge where both are 1;
   // while out_valid is high and out_ready low, out_pc/out_instr hold, and
   // out_valid never depends on out_ready.
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;

   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_pc,
      input  imem_rdata, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc,
      output imem_rdata, redirect_valid, redirect_pc, out_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Show-ahead instruction buffer with same-cycle push/pop and a synchronous flush.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output logic         empty,
   output logic [CW-1:0] count,
   output fetch_entry_t head
);

   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;

   assign empty  = (count == '0);
   assign do_pop = pop & !empty;
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: TMR-protected PC, one-cycle-latency memory requests, buffered output to decode.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   instruction_fetch_unit_if.master  bus,
   input  logic [1:0]                fault_inject,
   output logic                      tmr_fault
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [XLEN-1:0] pc0, pc1, pc2;
   logic [XLEN-1:0] pc_v, next_pc, inflight_pc;
   logic            run, inflight, issue, pop, push, empty;
   logic [CW-1:0]   count;
   logic [CW:0]     occ;
   fetch_entry_t    head, push_data;

   // The issue rule reserves a slot for every outstanding request, so the buffer never overflows.
   always_comb begin
      pc_v = (pc0 & pc1) | (pc1 & pc2) | (pc0 & pc2);
      pop  = !empty & bus.out_ready;
      push = inflight & !bus.redirect_valid;
      occ  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
      issue = run & !bus.redirect_valid & (occ < (CW+1)'(FIFO_DEPTH));
      if (bus.redirect_valid)
         next_pc = bus.redirect_pc & ~32'h3;
      else if (issue)
         next_pc = pc_v + 32'(INSTR_BYTES);
      else
         next_pc = pc_v;
      push_data.pc    = inflight_pc;
      push_data.instr = bus.imem_rdata;
   end

   assign bus.imem_req  = issue;
   assign bus.imem_addr = pc_v;
   assign bus.out_valid = !empty;
   assign bus.out_pc    = empty ? '0 : head.pc;
   assign bus.out_instr = empty ? '0 : head.instr;

   // Every copy is rewritten from the voted value each cycle, which scrubs a single upset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc0         <= RESET_PC;
         pc1         <= RESET_PC;
         pc2         <= RESET_PC;
         run         <= 1'b0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         tmr_fault   <= 1'b0;
      end else begin
         pc0         <= (fault_inject == 2'd1) ? (next_pc ^ 32'h1) : next_pc;
         pc1         <= (fault_inject == 2'd2) ? (next_pc ^ 32'h1) : next_pc;
         pc2         <= (fault_inject == 2'd3) ? (next_pc ^ 32'h1) : next_pc;
         run         <= 1'b1;
         inflight    <= issue;
         inflight_pc <= pc_v;
         tmr_fault   <= (pc0 != pc1) | (pc1 != pc2);
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (bus.redirect_valid),
      .empty     (empty),
      .count     (count),
      .head      (head)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit with a synchronous-read memory model.
module tb_instruction_fetch_unit;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] fault_inject;
   logic       tmr_fault;
   int         n_cmp = 0;
   int         n_fail = 0;

   instruction_fetch_unit_if bus_if ();

   instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus_if.master),
      .fault_inject (fault_inject),
      .tmr_fault    (tmr_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // Instruction memory: data for the address presented before the edge appears after it.
   always @(posedge clk) bus_if.imem_rdata <= instr_of(bus_if.imem_addr);

   typedef struct {
      logic        ready;
      logic        rv;
      logic [31:0] rpc;
      logic [1:0]  fi;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic        e_tmr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ready, input logic rv, input logic [31:0] rpc,
                      input logic [1:0] fi, input logic e_req, input logic [31:0] e_addr,
                      input logic e_valid, input logic [31:0] e_pc, input logic e_tmr);
      vec_t v;
      v.ready = ready; v.rv = rv; v.rpc = rpc; v.fi = fi;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_tmr = e_tmr;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc, input logic e_tmr);
      check({tag, " imem_req"},  32'(bus_if.imem_req),  32'(e_req));
      check({tag, " imem_addr"}, bus_if.imem_addr,      e_addr);
      check({tag, " out_valid"}, 32'(bus_if.out_valid), 32'(e_valid));
      check({tag, " out_pc"},    bus_if.out_pc,         e_valid ? e_pc : 32'h0);
      check({tag, " out_instr"}, bus_if.out_instr,      e_valid ? instr_of(e_pc) : 32'h0);
      check({tag, " tmr_fault"}, 32'(tmr_fault),        32'(e_tmr));
   endtask

   initial begin
      bus_if.out_ready      = 1'b1;
      bus_if.redirect_valid = 1'b0;
      bus_if.redirect_pc    = '0;
      fault_inject          = 2'd0;

      //   ready rv rpc           fi  req addr          valid pc            tmr
      // straight-line fetch from reset
      add(1, 0, 32'h0,        0,  1, 32'h00,        0, 32'h0,        0); // c1
      add(1, 0, 32'h0,        0,  1, 32'h04,        0, 32'h0,        0);
      add(1, 0, 32'h0,        0,  1, 32'h08,        1, 32'h00,       0);
      add(1, 0, 32'h0,        0,  1, 32'h0C,        1, 32'h04,       0);
      add(1, 0, 32'h0,        0,  1, 32'h10,        1, 32'h08,       0); // c5
      // decode stalls: issue stops once buffer + in-flight fill, head holds
      for (int i = 0; i < 5; i++)
         add(0, 0, 32'h0,     0,  0, 32'h14,        1, 32'h0C,       0); // c6..c10
      add(1, 0, 32'h0,        0,  1, 32'h14,        1, 32'h0C,       0);
      add(1, 0, 32'h0,        0,  1, 32'h18,        1, 32'h10,       0);
      add(0, 0, 32'h0,        0,  0, 32'h1C,        1, 32'h14,       0);
      add(0, 0, 32'h0,        0,  0, 32'h1C,        1, 32'h14,       0); // c14: buffer full
      // redirect to an unaligned target while full
      add(0, 1, 32'h43,       0,  0, 32'h1C,        1, 32'h14,       0); // c15 = R
      add(1, 0, 32'h0,        0,  1, 32'h40,        0, 32'h0,        0);
      add(1, 0, 32'h0,        0,  1, 32'h44,        0, 32'h0,        0);
      add(1, 0, 32'h0,        0,  1, 32'h48,        1, 32'h40,       0);
      // redirect coinciding with a pop, to the last word of the address space
      add(1, 1, 32'hFFFFFFFC, 0,  0, 32'h4C,        1, 32'h44,       0); // c19
      add(1, 0, 32'h0,        0,  1, 32'hFFFFFFFC,  0, 32'h0,        0);
      add(1, 0, 32'h0,        0,  1, 32'h00,        0, 32'h0,        0);
      add(1, 0, 32'h0,        0,  1, 32'h04,        1, 32'hFFFFFFFC, 0);
      add(1, 0, 32'h0,        0,  1, 32'h08,        1, 32'h00,       0);
      // single-copy upsets: copy 2, then copy 3
      add(1, 0, 32'h0,        2,  1, 32'h0C,        1, 32'h04,       0); // c24
      add(1, 0, 32'h0,        0,  1, 32'h10,        1, 32'h08,       0);
      add(1, 0, 32'h0,        0,  1, 32'h14,        1, 32'h0C,       1);
      add(1, 0, 32'h0,        3,  1, 32'h18,        1, 32'h10,       0);
      add(1, 0, 32'h0,        0,  1, 32'h1C,        1, 32'h14,       0);
      add(1, 0, 32'h0,        0,  1, 32'h20,        1, 32'h18,       1);
      add(1, 0, 32'h0,        0,  1, 32'h24,        1, 32'h1C,       0);
      add(1, 0, 32'h0,        1,  1, 32'h28,        1, 32'h20,       0); // c31: copy 1
      add(1, 0, 32'h0,        0,  1, 32'h2C,        1, 32'h24,       0);

      // reset state
      repeat (2) @(negedge clk);
      #1 check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // release between edges; no request until the first edge after release
      @(negedge clk);
      reset_n = 1'b1;
      #1 check("release imem_req", 32'(bus_if.imem_req), 32'h0);

      foreach (vecs[i]) begin
         @(negedge clk);
         bus_if.out_ready      = vecs[i].ready;
         bus_if.redirect_valid = vecs[i].rv;
         bus_if.redirect_pc    = vecs[i].rpc;
         fault_inject          = vecs[i].fi;
         #1 check_outputs($sformatf("vec%0d", i + 1), vecs[i].e_req, vecs[i].e_addr,
                          vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_tmr);
      end

      // fault pulse from copy 1 is visible now; reset lands mid-cycle on top of it
      @(negedge clk);
      bus_if.out_ready      = 1'b1;
      bus_if.redirect_valid = 1'b0;
      fault_inject          = 2'd0;
      #1 check_outputs("pre_rst", 1'b1, 32'h30, 1'b1, 32'h28, 1'b1);
      #2 reset_n = 1'b0;
      #1 check_outputs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      #1 check_outputs("held_rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      reset_n = 1'b1;
      #1 check("rerelease imem_req", 32'(bus_if.imem_req), 32'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1 check_outputs($sformatf("restart%0d", c), 1'b1, 32'(c * 4), c >= 2, 32'((c - 2) * 4), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Requester-side counterpart of instruction_memory. Owns the program counter, issues word addresses to the synchronous-read instruction memory (1-cycle read latency), and buffers the returned instructions in a small FIFO. Presents {pc, instruction} to decode over a valid/ready handshake and accepts branch/jump redirects. The PC is held as three copies with a majority vote (TMR); disagreement between copies is flagged and self-corrected.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, instruction buffer entries; a power of 2, minimum 2.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
imem_req  output  1  a fetch is issued this cycle at imem_addr.
imem_addr  output  32  fetch address; drives the pc input of instruction_memory; word-aligned.
imem_rdata  input  32  instruction for the address issued in the previous cycle.
redirect_valid  input  1  single-cycle pulse requesting a fetch restart.
redirect_pc  input  32  new PC; bits [1:0] are ignored and treated as 0.
out_valid  output  1  out_instr and out_pc are valid.
out_ready  input  1  decode accepts the current output.
out_instr  output  32  buffered instruction.
out_pc  output  32  address of out_instr.
fault_inject  input  2  test hook: 0 = none; 1..3 selects a PC copy that is corrupted this cycle.
tmr_fault  output  1  registered one-cycle pulse when the three PC copies disagree.

Behaviour:
- Reset (async assert, sync release): all three PC copies = RESET_PC; FIFO empty; inflight = 0; imem_req = 0; out_valid = 0; out_instr = 0; out_pc = 0; tmr_fault = 0.
- pc_v is the bitwise 2-of-3 majority of the PC copies. imem_addr = pc_v at all times.
- pop = out_valid & out_ready.
- Issue condition: imem_req = !redirect_valid & (count + inflight - pop < FIFO_DEPTH).
- On issue, every copy loads pc_v + 4. The PC wraps from 32'hFFFFFFFC to 0.
- Otherwise every copy loads pc_v. All copies are rewritten every cycle, so a single corrupted copy is corrected within one cycle.
- inflight <= imem_req & !redirect_valid. inflight also records the address issued (inflight_pc).
- Capture: when inflight = 1 and there is no redirect this cycle, push {inflight_pc, imem_rdata} into the FIFO. A push and a pop may happen in the same cycle. Overflow is impossible by the issue rule.
- Latency: the first imem_req is in the first cycle after reset release. out_valid rises 2 clocks later with out_pc = RESET_PC.
- Steady state with out_ready held at 1: one instruction per cycle.
- FIFO output is show-ahead: out_valid = !empty; out_instr and out_pc come from the head entry.
- Output stability: while out_valid = 1 and out_ready = 0, out_instr and out_pc hold stable.
- Redirect (cycle R):
  - FIFO flushed at the R edge.
  - Any in-flight response is dropped.
  - imem_req = 0 in cycle R.
  - All copies load {redirect_pc[31:2], 2'b00}.
  - Cycle R+1 issues the new PC; out_valid = 1 at R+2.
- Simultaneous redirect and pop: the redirect wins; the popped entry counts as consumed.
- fault_inject = k (nonzero): copy k is written with next_pc ^ 32'h00000001 that cycle.
- tmr_fault is registered as (copy0 != copy1) | (copy1 != copy2) and reported one cycle after the mismatch exists. It never stalls fetch.
- Reset asserted mid-operation: immediately returns every state element to its reset value, and in-flight data is discarded.

Decomposition:
- Shared package, fetch_pkg:
  - XLEN = 32
  - INSTR_BYTES = 4
  - default RESET_PC
  - typedef fetch_entry_t = {pc[31:0], instr[31:0]}
  - NOP constant 32'h00000013
- One natural sub-module, fetch_fifo: FIFO_DEPTH-entry synchronous FIFO with push, pop, flush, count, show-ahead head, and asynchronous active-low reset.
- The TMR voter stays inline as combinational logic.

Test Plan:
1. Reset release with RESET_PC = 0 and out_ready = 1 -> imem_addr 0,4,8,C,10 on consecutive cycles; out_pc 0,4,8… starting 2 cycles after release; out_instr matches the memory contents.
2. out_ready = 0 for 5 cycles after the first valid -> imem_req stops once count + inflight = 2; out_pc holds at 0. Release out_ready -> output continues 0,4,8 with no gap and no duplicate.
3. redirect_valid with redirect_pc = 32'h00000043 while FIFO is full -> out_valid = 0 at R+1; imem_addr = 32'h40 at R+1; out_pc = 32'h40 at R+2; stale 4/8 entries never appear.
4. Redirect to 32'hFFFFFFFC -> fetch addresses FFFFFFFC, then 00000000; out_pc sequence wraps identically.
5. fault_inject = 2 for one cycle -> tmr_fault pulses high for exactly one cycle; imem_addr sequence unchanged; copies equal again one cycle later.
6. reset_n pulled low mid-stream for one cycle -> out_valid, imem_req, and tmr_fault go to 0 immediately (asynchronously); after release, fetch restarts at RESET_PC.
